// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier: BPC bits of the multiplier are retired per BUSY cycle,
// signed operands are handled as magnitudes and the sign is restored in one FIX cycle.
//   state  | meaning
//   IDLE   | waiting for an operation, in_ready high
//   BUSY   | accumulating partial products, N cycles
//   FIX    | applying sign, computing overflow
//   DONE   | result presented, waiting for out_ready
module seq_multiplier #(
    parameter int WIDTH = 32,
    parameter int BPC   = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 is_signed,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     out_lo,
    output logic                 overflow
);

    localparam int N  = WIDTH / BPC;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    generate
        if (WIDTH < 2 || (BPC != 1 && BPC != 2 && BPC != 4 && BPC != 8) || (WIDTH % BPC) != 0) begin : g_param_check
            $error("seq_multiplier: illegal WIDTH/BPC combination");
        end
    endgenerate

    logic [1:0]           state_q,   state_d;
    logic [CW-1:0]        cnt_q,     cnt_d;
    logic [2*WIDTH-1:0]   a_sh_q,    a_sh_d;
    logic [WIDTH:0]       b_sh_q,    b_sh_d;
    logic                 neg_q,     neg_d;
    logic                 sgn_q,     sgn_d;
    logic [2*WIDTH-1:0]   acc_q,     acc_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 ovf_q,     ovf_d;

    logic [WIDTH:0]       a_ext, b_ext, a_mag, b_mag;
    logic [2*WIDTH-1:0]   partial;
    logic [2*WIDTH-1:0]   fixed;
    logic [WIDTH-1:0]     fixed_hi;
    logic                 ovf_calc;

    always_comb begin
        // One extra bit keeps |most-negative| exact.
        a_ext    = {is_signed & a[WIDTH-1], a};
        b_ext    = {is_signed & b[WIDTH-1], b};
        a_mag    = a_ext[WIDTH] ? -a_ext : a_ext;
        b_mag    = b_ext[WIDTH] ? -b_ext : b_ext;
        partial  = a_sh_q * {{(2*WIDTH-BPC){1'b0}}, b_sh_q[BPC-1:0]};
        fixed    = neg_q ? -acc_q : acc_q;
        fixed_hi = fixed[2*WIDTH-1:WIDTH];
        ovf_calc = sgn_q ? (fixed_hi != {WIDTH{fixed[WIDTH-1]}}) : (|fixed_hi);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        neg_d     = neg_q;
        sgn_d     = sgn_q;
        acc_d     = acc_q;
        product_d = product_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_sh_d  = {{(WIDTH-1){1'b0}}, a_mag};
                    b_sh_d  = b_mag;
                    neg_d   = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    sgn_d   = is_signed;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                // Multiplicand shifts up as multiplier digits shift out, so the
                // partial product is already aligned to its cnt*BPC weight.
                acc_d  = acc_q + partial;
                a_sh_d = a_sh_q << BPC;
                b_sh_d = b_sh_q >> BPC;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(N-1)) state_d = S_FIX;
            end
            S_FIX: begin
                product_d = fixed;
                ovf_d     = ovf_calc;
                state_d   = S_DONE;
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            a_sh_q    <= '0;
            b_sh_q    <= '0;
            neg_q     <= 1'b0;
            sgn_q     <= 1'b0;
            acc_q     <= '0;
            product_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_sh_q    <= a_sh_d;
            b_sh_q    <= b_sh_d;
            neg_q     <= neg_d;
            sgn_q     <= sgn_d;
            acc_q     <= acc_d;
            product_q <= product_d;
            ovf_q     <= ovf_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign product   = product_q;
    assign out_lo    = product_q[WIDTH-1:0];
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed cases on a default 32/4 instance plus a
// randomized sweep of all WIDTH/BPC combinations against an arithmetic model.
module tb_seq_multiplier;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid, is_signed, out_ready;
    logic [31:0] a, b;
    logic        in_ready, out_valid, overflow;
    logic [63:0] product;
    logic [31:0] out_lo;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    seq_multiplier #(.WIDTH(32), .BPC(4)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .is_signed(is_signed), .out_valid(out_valid),
        .out_ready(out_ready), .product(product), .out_lo(out_lo), .overflow(overflow)
    );

    logic        sw_iv [12];
    logic        sw_or [12];
    logic        sw_sg [12];
    logic [31:0] sw_a  [12];
    logic [31:0] sw_b  [12];
    logic        sw_ir [12];
    logic        sw_ov [12];
    logic        sw_of [12];
    logic [63:0] sw_p  [12];
    logic [31:0] sw_lo [12];

    for (genvar K = 0; K < 12; K++) begin : g_sw
        localparam int W = 8 << (K / 4);
        localparam int B = 1 << (K % 4);
        logic [2*W-1:0] p;
        logic [W-1:0]   lo;
        seq_multiplier #(.WIDTH(W), .BPC(B)) u_mul (
            .clock(clock), .reset(reset), .in_valid(sw_iv[K]), .in_ready(sw_ir[K]),
            .a(sw_a[K][W-1:0]), .b(sw_b[K][W-1:0]), .is_signed(sw_sg[K]),
            .out_valid(sw_ov[K]), .out_ready(sw_or[K]), .product(p), .out_lo(lo),
            .overflow(sw_of[K])
        );
        assign sw_p[K]  = 64'(p);
        assign sw_lo[K] = 32'(lo);
    end

    // Reference: interpret operands as integers, multiply exactly, range-check.
    function automatic void ref_mul(input int w, input logic [31:0] ra, input logic [31:0] rb,
                                    input bit s, output logic [63:0] p, output bit ovf);
        logic signed [127:0] x, y, r, one;
        one = 128'sd1;
        x = 128'(ra);
        y = 128'(rb);
        if (s && ra[w-1]) x = x - (one <<< w);
        if (s && rb[w-1]) y = y - (one <<< w);
        r = x * y;
        p = r[63:0];
        if (w < 32) p = p & ((64'd1 << (2*w)) - 64'd1);
        if (s) ovf = (r < -(one <<< (w-1))) || (r >= (one <<< (w-1)));
        else   ovf = (r >= (one <<< w));
    endfunction

    task automatic run_op(input logic [31:0] ra, input logic [31:0] rb, input bit rs, output int lat);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(posedge clock); #1;
            guard++;
        end
        a = ra; b = rb; is_signed = rs; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid  = 1'b0;
        a         = $urandom;
        b         = $urandom;
        is_signed = 1'($urandom);
        lat = -1;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clock); #1;
            if (out_valid) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        total++; if (product !== 64'd0)  begin bad++; $display("FAIL reset_product got=%h want=0", product); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_overflow got=%b want=0", overflow); end
        reset = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic test_unsigned_basic();
        int lat;
        run_op(32'h0000_1234, 32'h0000_5678, 1'b0, lat);
        total++; if (lat != 9) begin bad++; $display("FAIL ubasic_latency got=%0d want=9", lat); end
        total++; if (product !== 64'h0000_0000_0626_0060) begin bad++; $display("FAIL ubasic_product got=%h want=0000000006260060", product); end
        total++; if (out_lo !== 32'h0626_0060) begin bad++; $display("FAIL ubasic_out_lo got=%h want=06260060", out_lo); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ubasic_overflow got=%b want=0", overflow); end
        take_result();
    endtask

    task automatic test_signed_mixed();
        int lat;
        logic [31:0] legacy;
        legacy = 32'hFFFF_FFFD * 32'd7;
        run_op(32'hFFFF_FFFD, 32'd7, 1'b1, lat);
        total++; if (lat != 9) begin bad++; $display("FAIL smixed_latency got=%0d want=9", lat); end
        total++; if (product !== 64'hFFFF_FFFF_FFFF_FFEB) begin bad++; $display("FAIL smixed_product got=%h want=ffffffffffffffeb", product); end
        total++; if (out_lo !== legacy) begin bad++; $display("FAIL smixed_out_lo got=%h want=%h", out_lo, legacy); end
        total++; if (overflow !== 1'b0) begin bad++; $display("FAIL smixed_overflow got=%b want=0", overflow); end
        take_result();
    endtask

    task automatic test_extremes();
        logic [31:0] ea [3];
        logic [31:0] eb [3];
        bit          es [3];
        logic [63:0] ep [3];
        int lat;
        ea[0] = 32'h8000_0000; eb[0] = 32'h8000_0000; es[0] = 1'b1; ep[0] = 64'h4000_0000_0000_0000;
        ea[1] = 32'h8000_0000; eb[1] = 32'h8000_0000; es[1] = 1'b0; ep[1] = 64'h4000_0000_0000_0000;
        ea[2] = 32'hFFFF_FFFF; eb[2] = 32'hFFFF_FFFF; es[2] = 1'b0; ep[2] = 64'hFFFF_FFFE_0000_0001;
        for (int i = 0; i < 3; i++) begin
            run_op(ea[i], eb[i], es[i], lat);
            total++; if (lat != 9) begin bad++; $display("FAIL extreme%0d_latency got=%0d want=9", i, lat); end
            total++; if (product !== ep[i]) begin bad++; $display("FAIL extreme%0d_product got=%h want=%h", i, product, ep[i]); end
            total++; if (overflow !== 1'b1) begin bad++; $display("FAIL extreme%0d_overflow got=%b want=1", i, overflow); end
            take_result();
        end
    endtask

    task automatic test_back_pressure();
        int lat;
        run_op(32'd5, 32'd9, 1'b0, lat);
        total++; if (lat != 9) begin bad++; $display("FAIL bp_latency got=%0d want=9", lat); end
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'($urandom);
            a = $urandom; b = $urandom;
            @(posedge clock); #1;
            total++; if (product !== 64'd45) begin bad++; $display("FAIL bp_hold_product cyc=%0d got=%h want=45", c, product); end
            total++; if (in_ready !== 1'b0 || out_valid !== 1'b1) begin bad++; $display("FAIL bp_hold_flags cyc=%0d in_ready=%b out_valid=%b want 0/1", c, in_ready, out_valid); end
        end
        in_valid = 1'b0;
        take_result();
        total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
        total++; if (product !== 64'd45) begin bad++; $display("FAIL bp_idle_keep got=%h want=45", product); end
    endtask

    task automatic test_reset_mid();
        int lat;
        a = 32'h0000_FFFF; b = 32'h0000_FFFF; is_signed = 1'b0; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        total++; if (product !== 64'd0) begin bad++; $display("FAIL rmid_product got=%h want=0", product); end
        total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL rmid_flags out_valid=%b in_ready=%b want 0/1", out_valid, in_ready); end
        run_op(32'd2, 32'd3, 1'b0, lat);
        total++; if (lat != 9) begin bad++; $display("FAIL rmid_after_latency got=%0d want=9", lat); end
        total++; if (product !== 64'd6) begin bad++; $display("FAIL rmid_after_product got=%h want=6", product); end
        take_result();
    endtask

    function automatic logic [31:0] pick_operand(input int w, input logic [31:0] mask);
        int r;
        r = int'($urandom_range(0, 9));
        case (r)
            0:       return 32'd0;
            1:       return mask;
            2:       return 32'd1 << (w - 1);
            default: return $urandom & mask;
        endcase
    endfunction

    task automatic test_sweep(input int k, input int ops);
        int w, bpc, n, lat, guard;
        logic [31:0] mask, ra, rb;
        logic [63:0] ep;
        bit rs, eo;
        w    = 8 << (k / 4);
        bpc  = 1 << (k % 4);
        n    = w / bpc;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        for (int i = 0; i < ops; i++) begin
            ra = pick_operand(w, mask);
            rb = pick_operand(w, mask);
            rs = 1'($urandom);
            ref_mul(w, ra, rb, rs, ep, eo);
            guard = 0;
            while (!sw_ir[k] && guard < 100) begin
                @(posedge clock); #1;
                guard++;
            end
            sw_a[k] = ra; sw_b[k] = rb; sw_sg[k] = rs; sw_iv[k] = 1'b1;
            @(posedge clock); #1;
            sw_iv[k] = 1'b0;
            sw_a[k]  = $urandom;
            sw_b[k]  = $urandom;
            lat = -1;
            for (int c = 1; c <= 100; c++) begin
                @(posedge clock); #1;
                if (sw_ov[k]) begin
                    lat = c;
                    break;
                end
            end
            total++; if (lat != n + 1) begin bad++; $display("FAIL sweep_w%0d_b%0d_latency got=%0d want=%0d", w, bpc, lat, n + 1); end
            total++; if (sw_p[k] !== ep) begin bad++; $display("FAIL sweep_w%0d_b%0d_product a=%h b=%h s=%0d got=%h want=%h", w, bpc, ra, rb, rs, sw_p[k], ep); end
            total++; if (sw_lo[k] !== (ep[31:0] & mask)) begin bad++; $display("FAIL sweep_w%0d_b%0d_out_lo got=%h want=%h", w, bpc, sw_lo[k], ep[31:0] & mask); end
            total++; if (sw_of[k] !== eo) begin bad++; $display("FAIL sweep_w%0d_b%0d_overflow a=%h b=%h s=%0d got=%b want=%b", w, bpc, ra, rb, rs, sw_of[k], eo); end
            sw_or[k] = 1'b1;
            @(posedge clock); #1;
            sw_or[k] = 1'b0;
            total++; if (sw_ir[k] !== 1'b1) begin bad++; $display("FAIL sweep_w%0d_b%0d_ready_after_take got=%b want=1", w, bpc, sw_ir[k]); end
        end
    endtask

    task automatic test_sweep_all();
        for (int k = 0; k < 12; k++) begin
            automatic int kk = k;
            fork
                test_sweep(kk, 1000);
            join_none
        end
        wait fork;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        in_valid = 1'b0; is_signed = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        for (int k = 0; k < 12; k++) begin
            sw_iv[k] = 1'b0; sw_or[k] = 1'b0; sw_sg[k] = 1'b0; sw_a[k] = '0; sw_b[k] = '0;
        end
        test_reset();
        test_unsigned_basic();
        test_signed_mixed();
        test_extremes();
        test_back_pressure();
        test_reset_mid();
        test_sweep_all();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
